fpu_issue_arbiter: RTL and testbench
====================================

Name: fpu_issue_arbiter

Overview:
- Shares one pipelined, non-stallable FPU add/sub datapath between NUM_REQ requesters.
- Grants requests round-robin, drives the FPU operand, calc-mode and round-mode inputs from registers, and tracks in-flight operations with a tag shift register.
- Routes each FPU result back to the originating requester at a fixed latency.
- Provides a drain handshake so software can quiesce the datapath before a mode change or reset.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FPU_LATENCY, 5, clock edges from the arbiter's acceptance edge until the matching result is stable on fpu_result (at least 2).
- ID_W, 2, requester index width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester grant; transfer occurs when valid and ready are both high.
- req_in1  in  32*NUM_REQ  operand 1, IEEE-754 single; requester i occupies bits [32i+31:32i].
- req_in2  in  32*NUM_REQ  operand 2, same packing as req_in1.
- req_calc_mode  in  NUM_REQ  0 = add, 1 = sub.
- req_round_mode  in  2*NUM_REQ  rounding mode per requester.
- fpu_in1, fpu_in2  out  32  registered operands to the FPU.
- fpu_calc_mode  out  1  registered calc mode to the FPU.
- fpu_round_mode  out  2  registered round mode to the FPU.
- fpu_issue  out  1  high for one cycle when fpu_* carry a new operation.
- fpu_result  in  32  FPU result.
- resp_valid  out  NUM_REQ  one-hot result strobe; there is no backpressure on responses.
- resp_data  out  32  registered copy of fpu_result.
- drain_req  in  1  level-sensitive request to stop issuing and empty the pipe.
- drain_done  out  1  high while drained (IDLE state with the pipe empty).
- inflight  out  ID_W+2  number of operations in flight (saturation is not possible).

Behaviour:

Reset (reset low at a clock edge):
- State goes to RUN and the round-robin pointer goes to 0.
- Tag shift register is cleared.
- All outputs are 0: fpu_*, fpu_issue, resp_valid, resp_data, drain_done, inflight.
- Reset asserted mid-operation discards every in-flight tag; no responses are produced for those operations.

Arbitration (combinational):
- Scan requesters starting at the pointer, wrapping modulo NUM_REQ. The first requester with req_valid high is the winner.
- req_ready is one-hot on the winner, and only in state RUN.
- req_ready is all-zero when no requester is valid or when the state is not RUN.
- On acceptance, the pointer moves to (winner+1) mod NUM_REQ. Otherwise it holds.
- At most one acceptance per cycle. Throughput is one operation per cycle.

Issue (acceptance edge k):
- fpu_in1, fpu_in2, fpu_calc_mode and fpu_round_mode load the winner's fields.
- fpu_issue = 1 for the cycle after edge k. It is 0 in any cycle following an edge with no acceptance.
- fpu_* hold their last values when idle.

Tag pipe:
- FPU_LATENCY entries of {valid, id}. Entry 0 loads {accept, winner} and the pipe shifts every cycle.
- When the last entry is valid at edge k+FPU_LATENCY:
  - resp_data captures fpu_result;
  - resp_valid[id] = 1 for one cycle.
- Response ordering therefore equals issue order.

In-flight counter:
- inflight = number of valid tag entries.
- Update rule: +1 on acceptance, -1 on retirement, unchanged when both happen in the same cycle.

State machine:
- RUN: if drain_req = 1, go to DRAIN at the next edge. No acceptance occurs in the cycle where drain_req is first sampled high (req_ready is gated combinationally by drain_req).
- DRAIN: no grants. Go to IDLE when inflight = 0 and no retirement is pending this cycle.
- IDLE: drain_done = 1 and no grants. Go to RUN when drain_req = 0.
- drain_req deasserted while in DRAIN: still finish to IDLE, then return to RUN the next cycle.
- drain_req with an empty pipe: RUN to DRAIN to IDLE in 2 edges.

Other rules:
- drain_done is a registered output: it is 1 exactly while the state is IDLE.
- A requester that drops req_valid before being granted is simply skipped. Payload stability before the grant is not required.

Test Plan:
- Single op: req 0 sends 0x3F800000 + 0x40000000 (calc_mode = 0, round_mode = 00). Required: req_ready[0] = 1 in the same cycle, fpu_issue one cycle later with those operands, resp_valid = 0001 exactly 5 edges after acceptance, resp_data equal to the fpu_result driven by the model (0x40400000).
- All four requesters valid continuously for 8 cycles with pointer = 0. Required: grant order 0,1,2,3,0,1,2,3; inflight reaches 5; responses return in the same order, one per cycle.
- Requesters 1 and 3 only, with pointer initially 2. Required: grant order 3,1,3,1; requesters 0 and 2 never see req_ready.
- Drain: 3 ops issued, then drain_req = 1. Required: no further req_ready; all 3 responses arrive; drain_done rises the cycle after inflight reaches 0. Deassert drain_req: drain_done falls and grants resume in the next cycle.
- Reset low for one edge with 4 ops in flight. Required: all outputs 0 the next cycle, no resp_valid afterwards, inflight = 0, state RUN with pointer = 0.
- Simultaneous accept and retire in one cycle. Required: inflight unchanged.

Source files
------------

// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter that shares one fixed-latency pipelined FPU add/sub
// between NUM_REQ requesters, routes results back by tag and supports draining.
module fpu_issue_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int FPU_LATENCY = 5,
    parameter int ID_W        = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_in1,
    input  logic [32*NUM_REQ-1:0] req_in2,
    input  logic [NUM_REQ-1:0]    req_calc_mode,
    input  logic [2*NUM_REQ-1:0]  req_round_mode,
    output logic [31:0]           fpu_in1,
    output logic [31:0]           fpu_in2,
    output logic                  fpu_calc_mode,
    output logic [1:0]            fpu_round_mode,
    output logic                  fpu_issue,
    input  logic [31:0]           fpu_result,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_data,
    input  logic                  drain_req,
    output logic                  drain_done,
    output logic [ID_W+1:0]       inflight
);
    localparam int CNT_W = ID_W + 2;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} state_e;

    state_e                           state_q, state_d;
    logic [ID_W-1:0]                  ptr_q, ptr_d;
    logic [FPU_LATENCY-1:0]           tag_vld_q, tag_vld_d;
    logic [FPU_LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;
    logic [CNT_W-1:0]                 inflight_q, inflight_d;
    logic [31:0]                      fpu_in1_q, fpu_in1_d;
    logic [31:0]                      fpu_in2_q, fpu_in2_d;
    logic                             fpu_calc_mode_q, fpu_calc_mode_d;
    logic [1:0]                       fpu_round_mode_q, fpu_round_mode_d;
    logic                             fpu_issue_q, fpu_issue_d;
    logic [NUM_REQ-1:0]               resp_valid_q, resp_valid_d;
    logic [31:0]                      resp_data_q, resp_data_d;
    logic                             drain_done_q, drain_done_d;

    logic            found;
    logic            accept;
    logic            retire;
    logic [ID_W-1:0] winner;
    int              cand;
    logic [31:0]     sel_in1, sel_in2;
    logic            sel_calc_mode;
    logic [1:0]      sel_round_mode;

    // Round-robin scan starting at the pointer; grants are gated by state and drain_req.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        found     = 1'b0;
        winner    = ptr_q;
        cand      = 0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && req_valid[ID_W'(cand)]) begin
                found  = 1'b1;
                winner = ID_W'(cand);
            end
        end
        accept = found && (state_q == ST_RUN) && !drain_req;
        if (accept) req_ready[winner] = 1'b1;
    end

    always_comb begin
        sel_in1        = '0;
        sel_in2        = '0;
        sel_calc_mode  = 1'b0;
        sel_round_mode = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == winner) begin
                sel_in1        = req_in1[32*i +: 32];
                sel_in2        = req_in2[32*i +: 32];
                sel_calc_mode  = req_calc_mode[i];
                sel_round_mode = req_round_mode[2*i +: 2];
            end
        end
    end

    always_comb begin
        retire = tag_vld_q[FPU_LATENCY-1];

        ptr_d = ptr_q;
        if (accept) ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

        fpu_in1_d        = accept ? sel_in1 : fpu_in1_q;
        fpu_in2_d        = accept ? sel_in2 : fpu_in2_q;
        fpu_calc_mode_d  = accept ? sel_calc_mode : fpu_calc_mode_q;
        fpu_round_mode_d = accept ? sel_round_mode : fpu_round_mode_q;
        fpu_issue_d      = accept;

        tag_vld_d = {tag_vld_q[FPU_LATENCY-2:0], accept};
        tag_id_d  = {tag_id_q[FPU_LATENCY-2:0], winner};

        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        if (retire) begin
            resp_valid_d[tag_id_q[FPU_LATENCY-1]] = 1'b1;
            resp_data_d                           = fpu_result;
        end

        case ({accept, retire})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: if (inflight_q == '0 && !retire) state_d = ST_IDLE;
            ST_IDLE:  if (!drain_req) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        drain_done_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q          <= ST_RUN;
            ptr_q            <= '0;
            tag_vld_q        <= '0;
            tag_id_q         <= '0;
            inflight_q       <= '0;
            fpu_in1_q        <= '0;
            fpu_in2_q        <= '0;
            fpu_calc_mode_q  <= 1'b0;
            fpu_round_mode_q <= '0;
            fpu_issue_q      <= 1'b0;
            resp_valid_q     <= '0;
            resp_data_q      <= '0;
            drain_done_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            tag_vld_q        <= tag_vld_d;
            tag_id_q         <= tag_id_d;
            inflight_q       <= inflight_d;
            fpu_in1_q        <= fpu_in1_d;
            fpu_in2_q        <= fpu_in2_d;
            fpu_calc_mode_q  <= fpu_calc_mode_d;
            fpu_round_mode_q <= fpu_round_mode_d;
            fpu_issue_q      <= fpu_issue_d;
            resp_valid_q     <= resp_valid_d;
            resp_data_q      <= resp_data_d;
            drain_done_q     <= drain_done_d;
        end
    end

    assign fpu_in1        = fpu_in1_q;
    assign fpu_in2        = fpu_in2_q;
    assign fpu_calc_mode  = fpu_calc_mode_q;
    assign fpu_round_mode = fpu_round_mode_q;
    assign fpu_issue      = fpu_issue_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign drain_done     = drain_done_q;
    assign inflight       = inflight_q;

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Randomized bench for fpu_issue_arbiter: a transaction-level model (operation queue
// with due times) predicts every output each cycle; directed scenarios pin it with literals.
module tb_fpu_issue_arbiter;
    localparam int N   = 4;
    localparam int L   = 5;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [32*N-1:0]  req_in1;
    logic [32*N-1:0]  req_in2;
    logic [N-1:0]     req_calc_mode;
    logic [2*N-1:0]   req_round_mode;
    logic [31:0]      fpu_in1;
    logic [31:0]      fpu_in2;
    logic             fpu_calc_mode;
    logic [1:0]       fpu_round_mode;
    logic             fpu_issue;
    logic [31:0]      fpu_result;
    logic [N-1:0]     resp_valid;
    logic [31:0]      resp_data;
    logic             drain_req;
    logic             drain_done;
    logic [IDW+1:0]   inflight;

    fpu_issue_arbiter #(.NUM_REQ(N), .FPU_LATENCY(L), .ID_W(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2),
        .req_calc_mode(req_calc_mode), .req_round_mode(req_round_mode),
        .fpu_in1(fpu_in1), .fpu_in2(fpu_in2),
        .fpu_calc_mode(fpu_calc_mode), .fpu_round_mode(fpu_round_mode),
        .fpu_issue(fpu_issue), .fpu_result(fpu_result),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .drain_req(drain_req), .drain_done(drain_done), .inflight(inflight)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Stand-in arithmetic: the pinned 1.0 + 2.0 case is exact, everything else is a tagging hash.
    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic cm, input logic [1:0] rm);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !cm) return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + {29'd0, cm, rm};
    endfunction

    typedef struct {
        int          id;
        int          due;
        logic [31:0] data;
    } op_t;

    op_t         ops[$];
    int          m_state;   // 0 run, 1 drain, 2 idle
    int          m_ptr;
    int          cyc;
    bit          live;
    logic [31:0] e_in1, e_in2, e_resp_data;
    logic        e_cm, e_issue, e_done;
    logic [1:0]  e_rm;
    logic [N-1:0] e_resp_valid;
    logic [N-1:0] seen_ready;

    logic        fv[L];
    logic [31:0] fr[L];

    // One clock cycle: compare against the model, advance the model, step the FPU stand-in.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        int           win, c, edge_n, sz;
        #1;
        win = -1;
        if (m_state == 0 && !drain_req)
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (win < 0 && req_valid[c]) win = c;
            end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        seen_ready = req_ready;
        if (live) begin
            check("req_ready", req_ready, exp_ready);
            check("fpu_in1", fpu_in1, e_in1);
            check("fpu_in2", fpu_in2, e_in2);
            check("fpu_calc_mode", fpu_calc_mode, e_cm);
            check("fpu_round_mode", fpu_round_mode, e_rm);
            check("fpu_issue", fpu_issue, e_issue);
            check("resp_valid", resp_valid, e_resp_valid);
            check("resp_data", resp_data, e_resp_data);
            check("drain_done", drain_done, e_done);
            check("inflight", inflight, ops.size());
        end
        edge_n = cyc + 1;
        sz     = ops.size();
        if (!reset) begin
            ops.delete();
            m_state = 0; m_ptr = 0; live = 1'b1;
            e_in1 = '0; e_in2 = '0; e_cm = 1'b0; e_rm = '0; e_issue = 1'b0;
            e_resp_valid = '0; e_resp_data = '0; e_done = 1'b0;
        end else begin
            e_resp_valid = '0;
            if (sz > 0 && ops[0].due == edge_n) begin
                e_resp_valid[ops[0].id] = 1'b1;
                e_resp_data = ops[0].data;
                void'(ops.pop_front());
            end
            e_issue = (win >= 0);
            if (win >= 0) begin
                e_in1 = req_in1[32*win +: 32];
                e_in2 = req_in2[32*win +: 32];
                e_cm  = req_calc_mode[win];
                e_rm  = req_round_mode[2*win +: 2];
                ops.push_back('{win, edge_n + L, fpu_fn(e_in1, e_in2, e_cm, e_rm)});
                m_ptr = (win + 1) % N;
            end
            case (m_state)
                0:       if (drain_req) m_state = 1;
                1:       if (sz == 0) m_state = 2;
                default: if (!drain_req) m_state = 0;
            endcase
            e_done = (m_state == 2);
        end
        cyc = edge_n;
        @(posedge clk);
        #1;
        for (int j = L - 1; j > 0; j--) begin
            fv[j] = fv[j-1];
            fr[j] = fr[j-1];
        end
        fv[0] = fpu_issue;
        fr[0] = fpu_fn(fpu_in1, fpu_in2, fpu_calc_mode, fpu_round_mode);
        fpu_result = (fv[L-1] === 1'b1) ? fr[L-1] : $urandom;
        @(negedge clk);
    endtask

    task automatic randomize_payload();
        for (int i = 0; i < N; i++) begin
            req_in1[32*i +: 32]       = $urandom;
            req_in2[32*i +: 32]       = $urandom;
            req_calc_mode[i]          = 1'($urandom);
            req_round_mode[2*i +: 2]  = 2'($urandom);
        end
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    int grants[$];
    int resps[$];
    int resp_cyc[$];
    int infl[8];
    int t_zero, t_done, n_resp;
    logic [N-1:0] acc;

    initial begin
        reset = 1'b0; req_valid = '0; drain_req = 1'b0;
        req_in1 = '0; req_in2 = '0; req_calc_mode = '0; req_round_mode = '0;
        fpu_result = '0;
        for (int j = 0; j < L; j++) begin fv[j] = 1'b0; fr[j] = '0; end
        m_state = 0; m_ptr = 0; cyc = 0; live = 1'b0;
        @(negedge clk);
        cycle(); cycle();
        reset = 1'b1;
        check("rst_inflight", inflight, 0);
        check("rst_drain_done", drain_done, 0);
        check("rst_fpu_issue", fpu_issue, 0);

        // Single op from requester 0: 1.0 + 2.0
        req_valid = 4'b0001;
        req_in1[31:0] = 32'h3F80_0000;
        req_in2[31:0] = 32'h4000_0000;
        cycle();
        check("single_ready", seen_ready, 4'b0001);
        check("single_issue", fpu_issue, 1);
        check("single_in1", fpu_in1, 32'h3F80_0000);
        check("single_in2", fpu_in2, 32'h4000_0000);
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("single_resp_early", resp_valid, 0);
        end
        cycle();
        check("single_resp_valid", resp_valid, 4'b0001);
        check("single_resp_data", resp_data, 32'h4040_0000);
        idle(3);

        // Pointer back to 0, then all four requesters continuously for 8 cycles
        reset = 1'b0; cycle(); reset = 1'b1;
        randomize_payload();
        req_valid = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) req_valid = '0;
            cycle();
            if (k < 8) begin
                grants.push_back(oh_idx(seen_ready));
                infl[k] = int'(inflight);
            end
            if (resp_valid != '0) begin
                resps.push_back(oh_idx(resp_valid));
                resp_cyc.push_back(k);
            end
        end
        check("rr4_grant_count", grants.size(), 8);
        for (int i = 0; i < grants.size(); i++) check("rr4_grant_order", grants[i], i % 4);
        check("rr4_inflight_peak", infl[4], 5);
        check("accept_retire_hold", infl[5], 5);
        check("rr4_inflight_end", infl[7], 5);
        check("rr4_resp_count", resps.size(), 8);
        for (int i = 0; i < resps.size(); i++) check("rr4_resp_order", resps[i], i % 4);
        if (resp_cyc.size() == 8) check("rr4_resp_back_to_back", resp_cyc[7] - resp_cyc[0], 7);
        idle(2);

        // Move pointer to 2 via requester 1, then only requesters 1 and 3
        req_valid = 4'b0010; cycle();
        grants.delete();
        acc = '0;
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            randomize_payload();
            cycle();
            grants.push_back(oh_idx(seen_ready));
            acc |= seen_ready;
        end
        check("rr2_g0", grants[0], 3);
        check("rr2_g1", grants[1], 1);
        check("rr2_g2", grants[2], 3);
        check("rr2_g3", grants[3], 1);
        check("rr2_never_0_2", acc & 4'b0101, 0);
        idle(8);

        // Drain with 3 ops in flight
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) cycle();
        drain_req = 1'b1;
        acc = '0; n_resp = 0; t_zero = -1; t_done = -1;
        for (int k = 0; k < 30 && t_done < 0; k++) begin
            cycle();
            acc |= seen_ready;
            if (resp_valid != '0) n_resp++;
            if (inflight == 0 && t_zero < 0) t_zero = k;
            if (drain_done && t_done < 0) t_done = k;
        end
        check("drain_no_grant", acc, 0);
        check("drain_resp_count", n_resp, 3);
        check("drain_done_seen", t_done >= 0, 1);
        check("drain_done_after_empty", t_done - t_zero, 1);
        cycle();
        check("drain_done_holds", drain_done, 1);
        drain_req = 1'b0;
        cycle();
        check("drain_done_falls", drain_done, 0);
        #1;
        check("grant_resumes", req_ready, 4'b0010);
        idle(8);

        // Reset with 4 ops in flight
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) cycle();
        check("pre_reset_inflight", inflight, 4);
        reset = 1'b0; cycle(); reset = 1'b1;
        req_valid = '0;
        check("reset_resp_valid", resp_valid, 0);
        check("reset_resp_data", resp_data, 0);
        check("reset_fpu_in1", fpu_in1, 0);
        check("reset_fpu_issue", fpu_issue, 0);
        check("reset_inflight", inflight, 0);
        acc = '0;
        for (int k = 0; k < 8; k++) begin cycle(); acc |= resp_valid; end
        check("reset_no_resp", acc, 0);
        req_valid = 4'b1111; cycle();
        check("reset_ptr_zero", seen_ready, 4'b0001);
        idle(8);

        // Randomized traffic with occasional drains and resets
        for (int k = 0; k < 800; k++) begin
            randomize_payload();
            req_valid = N'($urandom);
            if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
            reset = ($urandom_range(0, 299) != 0);
            cycle();
        end
        reset = 1'b1; drain_req = 1'b0;
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
